spectro_frame_receiver: RTL and testbench

//   Receive end of the spectrogram extractor serial link. Samples serial_out/SL/a[3:0]/ovf_global

---
 rtl/spectro_frame_receiver_if.sv | 32 +++
 rtl/spectro_frame_receiver.sv | 121 ++++++++++++
 tb/tb_spectro_frame_receiver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spectro_frame_receiver_if.sv
// rtl/spectro_frame_receiver_if.sv - serial link, word/frame outputs and bank read port
interface spectro_frame_receiver_if #(
   parameter int WORD_W = 12,
   parameter int ADDR_W = 4
);
   logic              serial_in;
   logic              sl_in;
   logic [ADDR_W-1:0] addr_in;
   logic              ovf_in;
   logic              word_valid;
   logic [ADDR_W-1:0] word_addr;
   logic [WORD_W-1:0] word_data;
   logic              frame_valid;
   logic              frame_ovf;
   logic              frame_err;
   logic              short_err;
   logic [15:0]       frame_cnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [WORD_W-1:0] rd_data;

   modport master (
      output serial_in, sl_in, addr_in, ovf_in, rd_addr,
      input  word_valid, word_addr, word_data, frame_valid, frame_ovf,
             frame_err, short_err, frame_cnt, rd_data
   );

   modport slave (
      input  serial_in, sl_in, addr_in, ovf_in, rd_addr,
      output word_valid, word_addr, word_data, frame_valid, frame_ovf,
             frame_err, short_err, frame_cnt, rd_data
   );
endinterface

// File: rtl/spectro_frame_receiver.sv
// rtl/spectro_frame_receiver.sv - rebuilds 12-bit words from the extractor link into a 16-entry bank
// and flags each complete frame when the last address (N_CH-1) arrives.
module spectro_frame_receiver #(
   parameter int WORD_W = 12,
   parameter int N_CH   = 16,
   parameter int ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   spectro_frame_receiver_if.slave link
);
   localparam int CNT_W = $clog2(WORD_W + 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t            r_state;
   logic [WORD_W-2:0] r_sreg;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [N_CH-1:0]   r_mask;
   logic              r_ovf_acc;
   logic [WORD_W-1:0] r_bank [N_CH];

   logic              r_word_valid;
   logic [ADDR_W-1:0] r_word_addr;
   logic [WORD_W-1:0] r_word_data;
   logic              r_frame_valid;
   logic              r_frame_ovf;
   logic              r_frame_err;
   logic              r_short_err;
   logic [15:0]       r_frame_cnt;

   logic [WORD_W-1:0] w_word;
   logic              w_word_done;
   logic [N_CH-1:0]   w_mask_next;
   logic              w_frame_close;

   // The final bit is taken straight from the pin so the word lands on the edge that samples it.
   assign w_word        = {r_sreg, link.serial_in};
   assign w_word_done   = (r_state == S_SHIFT) && link.sl_in && (r_bit_cnt == CNT_W'(WORD_W - 1));
   assign w_mask_next   = r_mask | (N_CH'(1) << r_cur_addr);
   assign w_frame_close = w_word_done && (r_cur_addr == ADDR_W'(N_CH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_sreg        <= '0;
         r_bit_cnt     <= '0;
         r_cur_addr    <= '0;
         r_mask        <= '0;
         r_ovf_acc     <= 1'b0;
         r_word_valid  <= 1'b0;
         r_word_addr   <= '0;
         r_word_data   <= '0;
         r_frame_valid <= 1'b0;
         r_frame_ovf   <= 1'b0;
         r_frame_err   <= 1'b0;
         r_short_err   <= 1'b0;
         r_frame_cnt   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         r_word_valid  <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_short_err   <= 1'b0;
         r_ovf_acc     <= r_ovf_acc | link.ovf_in;

         case (r_state)
            S_IDLE: begin
               if (!link.sl_in) begin
                  r_cur_addr <= link.addr_in;
                  r_bit_cnt  <= '0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (!link.sl_in) begin
                  r_short_err <= 1'b1;
                  r_cur_addr  <= link.addr_in;
                  r_bit_cnt   <= '0;
               end else if (w_word_done) begin
                  r_bank[r_cur_addr] <= w_word;
                  r_word_data        <= w_word;
                  r_word_addr        <= r_cur_addr;
                  r_word_valid       <= 1'b1;
                  r_mask             <= w_mask_next;
                  r_state            <= S_IDLE;
                  if (w_frame_close) begin
                     // Closing a frame restarts both the mask and the overflow window.
                     r_frame_ovf <= r_ovf_acc | link.ovf_in;
                     r_mask      <= '0;
                     r_ovf_acc   <= 1'b0;
                     if (&w_mask_next) begin
                        r_frame_valid <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end
               end else begin
                  r_sreg    <= {r_sreg[WORD_W-3:0], link.serial_in};
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign link.word_valid  = r_word_valid;
   assign link.word_addr   = r_word_addr;
   assign link.word_data   = r_word_data;
   assign link.frame_valid = r_frame_valid;
   assign link.frame_ovf   = r_frame_ovf;
   assign link.frame_err   = r_frame_err;
   assign link.short_err   = r_short_err;
   assign link.frame_cnt   = r_frame_cnt;
   assign link.rd_data     = r_bank[link.rd_addr];
endmodule

// File: tb/tb_spectro_frame_receiver.sv
// tb/tb_spectro_frame_receiver.sv - directed vectors for spectro_frame_receiver
module tb_spectro_frame_receiver;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spectro_frame_receiver_if #(.WORD_W(12), .ADDR_W(4)) link ();

   spectro_frame_receiver dut (
      .clk   (clk),
      .reset (reset),
      .link  (link.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_word  = 0;
   int n_frame = 0;
   int n_ferr  = 0;
   int n_short = 0;
   logic last_fovf = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (link.word_valid)  n_word  <= n_word + 1;
         if (link.frame_valid) begin
            n_frame   <= n_frame + 1;
            last_fovf <= link.frame_ovf;
         end
         if (link.frame_err)   n_ferr  <= n_ferr + 1;
         if (link.short_err)   n_short <= n_short + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         link.sl_in     = 1'b1;
         link.serial_in = 1'b0;
         link.ovf_in    = 1'b0;
      end
   endtask

   task automatic send_word(input logic [3:0] a, input logic [11:0] d, input int nbits);
      @(negedge clk);
      link.sl_in     = 1'b0;
      link.addr_in   = a;
      link.serial_in = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         link.sl_in     = 1'b1;
         link.serial_in = d[11-i];
      end
   endtask

   // skip: address left out (-1 for none); ovf_at: address preceded by a one-cycle ovf pulse.
   task automatic send_frame(input int skip, input int ovf_at);
      for (int a = 0; a < 16; a++) begin
         if (a == ovf_at) begin
            @(negedge clk);
            link.sl_in  = 1'b1;
            link.ovf_in = 1'b1;
            @(negedge clk);
            link.ovf_in = 1'b0;
         end
         if (a != skip) send_word(4'(a), 12'(a * 12'h111), 12);
      end
      idle(3);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] a, input logic [11:0] exp);
      link.rd_addr = a;
      #1;
      check(tag, 32'(link.rd_data), 32'(exp));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wv"},  32'(link.word_valid),  32'd0);
      check({tag, "_wa"},  32'(link.word_addr),   32'd0);
      check({tag, "_wd"},  32'(link.word_data),   32'd0);
      check({tag, "_fv"},  32'(link.frame_valid), 32'd0);
      check({tag, "_fo"},  32'(link.frame_ovf),   32'd0);
      check({tag, "_fe"},  32'(link.frame_err),   32'd0);
      check({tag, "_se"},  32'(link.short_err),   32'd0);
      check({tag, "_cnt"}, 32'(link.frame_cnt),   32'd0);
   endtask

   int w0, f0, e0, s0;

   initial begin
      link.serial_in = 1'b0;
      link.sl_in     = 1'b1;
      link.addr_in   = 4'd0;
      link.ovf_in    = 1'b0;
      link.rd_addr   = 4'd0;

      repeat (3) @(negedge clk);
      check_all_zero("rst");
      rd_check("rst_rd9", 4'd9, 12'h000);
      reset = 1'b0;
      idle(2);

      // 1: full clean frame
      w0 = n_word; f0 = n_frame;
      send_frame(-1, -1);
      check("t1_words", 32'(n_word - w0), 32'd16);
      check("t1_frames", 32'(n_frame - f0), 32'd1);
      check("t1_cnt", 32'(link.frame_cnt), 32'd1);
      check("t1_wdata", 32'(link.word_data), 32'hFFF);
      check("t1_waddr", 32'(link.word_addr), 32'd15);
      rd_check("t1_rd5", 4'd5, 12'h555);
      rd_check("t1_rd15", 4'd15, 12'hFFF);

      // 2: short word then a good word; word_valid one cycle after the last bit
      s0 = n_short;
      send_word(4'd3, 12'hA5C, 7);
      send_word(4'd4, 12'h123, 12);
      @(negedge clk);
      link.sl_in = 1'b1;
      check("t2_wv_lat", 32'(link.word_valid), 32'd1);
      check("t2_wd", 32'(link.word_data), 32'h123);
      check("t2_wa", 32'(link.word_addr), 32'd4);
      idle(2);
      check("t2_wv_pulse", 32'(link.word_valid), 32'd0);
      check("t2_short", 32'(n_short - s0), 32'd1);
      rd_check("t2_rd3", 4'd3, 12'h333);
      rd_check("t2_rd4", 4'd4, 12'h123);

      // 3: frame missing address 7
      f0 = n_frame; e0 = n_ferr;
      send_frame(7, -1);
      check("t3_err", 32'(n_ferr - e0), 32'd1);
      check("t3_fv", 32'(n_frame - f0), 32'd0);
      check("t3_cnt", 32'(link.frame_cnt), 32'd1);

      // 4: overflow frame then clean frame (also proves mask cleared after t3)
      f0 = n_frame; e0 = n_ferr;
      send_frame(-1, 8);
      check("t4_fv", 32'(n_frame - f0), 32'd1);
      check("t4_ovf", 32'(last_fovf), 32'd1);
      check("t4_cnt", 32'(link.frame_cnt), 32'd2);
      send_frame(-1, -1);
      check("t4_fv2", 32'(n_frame - f0), 32'd2);
      check("t4_ovf2", 32'(last_fovf), 32'd0);
      check("t4_err", 32'(n_ferr - e0), 32'd0);
      check("t4_cnt2", 32'(link.frame_cnt), 32'd3);

      // 5: reset mid-word
      send_word(4'd2, 12'hABC, 6);
      @(negedge clk);
      reset = 1'b1;
      link.sl_in = 1'b1;
      @(negedge clk);
      check_all_zero("t5");
      rd_check("t5_rd2", 4'd2, 12'h000);
      rd_check("t5_rd5", 4'd5, 12'h000);
      reset = 1'b0;
      idle(2);
      f0 = n_frame;
      send_frame(-1, -1);
      check("t5_fv", 32'(n_frame - f0), 32'd1);
      check("t5_cnt", 32'(link.frame_cnt), 32'd1);
      rd_check("t5_rd2b", 4'd2, 12'h222);

      // 6: frame counter wrap
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      @(negedge clk);
      check("t6_pre", 32'(link.frame_cnt), 32'hFFFF);
      f0 = n_frame;
      send_frame(-1, -1);
      check("t6_fv", 32'(n_frame - f0), 32'd1);
      check("t6_wrap", 32'(link.frame_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
